// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply / restoring divide unit producing HI/LO in 33 cycles.
// Define MDU_DIV_EN to build the divide datapath; otherwise divide ops complete as no-ops.
module mult_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A_opdat,
  input  logic [31:0] B_opdat,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        sa_q, sa_d, sb_q, sb_d;
  logic [31:0] opnd_q, opnd_d;
  logic [31:0] hacc_q, hacc_d, lacc_q, lacc_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        done_q, done_d;

  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [63:0] prod, prod_fix;

  // Signed ops work on magnitudes; 0x80000000 maps to itself as an unsigned magnitude.
  assign a_mag    = (op[0] & A_opdat[31]) ? -A_opdat : A_opdat;
  assign b_mag    = (op[0] & B_opdat[31]) ? -B_opdat : B_opdat;
  assign mul_sum  = {1'b0, hacc_q} + (lacc_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign prod     = {hacc_q, lacc_q};
  assign prod_fix = (sa_q ^ sb_q) ? -prod : prod;

`ifdef MDU_DIV_EN
  logic        dz_q, dz_d, dbz_q, dbz_d;
  logic [32:0] partial;
  logic [31:0] rem_sub;
  logic        trial_ok;

  assign partial  = {hacc_q, lacc_q[31]};
  assign trial_ok = partial >= {1'b0, opnd_q};
  // When the trial succeeds the difference is below the divisor, so 32 bits suffice.
  assign rem_sub  = partial[31:0] - opnd_q;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    opnd_d   = opnd_q;
    hacc_d   = hacc_q;
    lacc_d   = lacc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
`ifdef MDU_DIV_EN
    dz_d     = dz_q;
    dbz_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          is_div_d = op[1];
          sa_d     = op[0] & A_opdat[31];
          sb_d     = op[0] & B_opdat[31];
          cnt_d    = 5'd0;
          hacc_d   = 32'd0;
          if (op[1]) begin
            opnd_d = b_mag;
            lacc_d = a_mag;
`ifdef MDU_DIV_EN
            dz_d    = (B_opdat == 32'd0);
            state_d = (B_opdat == 32'd0) ? FIX : CALC;
`else
            state_d = FIX;
`endif
          end else begin
            opnd_d  = a_mag;
            lacc_d  = b_mag;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q + 5'd1;
`ifdef MDU_DIV_EN
        if (is_div_q) begin
          hacc_d = trial_ok ? rem_sub : partial[31:0];
          lacc_d = {lacc_q[30:0], trial_ok};
        end else begin
          hacc_d = mul_sum[32:1];
          lacc_d = {mul_sum[0], lacc_q[31:1]};
        end
`else
        hacc_d = mul_sum[32:1];
        lacc_d = {mul_sum[0], lacc_q[31:1]};
`endif
        if (cnt_q == 5'd31) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (!is_div_q) begin
          {hi_d, lo_d} = prod_fix;
        end
`ifdef MDU_DIV_EN
        else if (dz_q) begin
          dbz_d = 1'b1;
        end else begin
          // Quotient sign from sign mismatch; remainder follows the dividend.
          lo_d = (sa_q ^ sb_q) ? -lacc_q : lacc_q;
          hi_d = sa_q ? -hacc_q : hacc_q;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      opnd_q   <= 32'd0;
      hacc_q   <= 32'd0;
      lacc_q   <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
`ifdef MDU_DIV_EN
      dz_q     <= 1'b0;
      dbz_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      opnd_q   <= opnd_d;
      hacc_q   <= hacc_d;
      lacc_q   <= lacc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
`ifdef MDU_DIV_EN
      dz_q     <= dz_d;
      dbz_q    <= dbz_d;
`endif
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
`ifdef MDU_DIV_EN
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed and random ops against an arithmetic model.
module tb_mult_div_unit;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [1:0]  op;
  logic [31:0] A_opdat, B_opdat;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_hi = 32'd0, exp_lo = 32'd0;

  mult_div_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .A_opdat(A_opdat), .B_opdat(B_opdat),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] h, output logic [31:0] l,
                       output logic dz, output int lat);
    h = exp_hi; l = exp_lo; dz = 1'b0; lat = 33;
    case (o)
      2'b00: {h, l} = {32'd0, a} * {32'd0, b};
      2'b01: begin
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        {h, l} = p;
      end
      default: begin
`ifdef MDU_DIV_EN
        if (b == 32'd0) begin
          dz = 1'b1; lat = 1;
        end else if (o == 2'b10) begin
          l = a / b; h = a % b;
        end else begin
          longint q, r;
          q = longint'($signed(a)) / longint'($signed(b));
          r = longint'($signed(a)) % longint'($signed(b));
          l = q[31:0]; h = r[31:0];
        end
`else
        lat = 1;
`endif
      end
    endcase
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge where done is first seen high.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int glitch_at, input string tag);
    logic [31:0] eh, el;
    logic edz;
    int lat, k;
    model(o, a, b, eh, el, edz, lat);
    start = 1'b1; op = o; A_opdat = a; B_opdat = b;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); A_opdat = $urandom; B_opdat = $urandom;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL %s busy_after_start got=%b want=1", tag, busy); end
    k = 0;
    while (done !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
      if (k == glitch_at) begin
        start = 1'b1; op = 2'($urandom); A_opdat = $urandom; B_opdat = $urandom;
      end else start = 1'b0;
      if (k == 16) begin
        total++;
        if (hi !== exp_hi || lo !== exp_lo) begin
          bad++; $display("FAIL %s hold_mid got=%h_%h want=%h_%h", tag, hi, lo, exp_hi, exp_lo);
        end
      end
    end
    start = 1'b0;
    total++;
    if (k != lat) begin bad++; $display("FAIL %s latency got=%0d want=%0d", tag, k, lat); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL %s busy_with_done got=%b want=0", tag, busy); end
    total++;
    if (hi !== eh || lo !== el) begin
      bad++; $display("FAIL %s result got=%h_%h want=%h_%h (op=%0d a=%h b=%h)", tag, hi, lo, eh, el, o, a, b);
    end
    total++;
    if (div_by_zero !== edz) begin bad++; $display("FAIL %s div_by_zero got=%b want=%b", tag, div_by_zero, edz); end
    exp_hi = eh; exp_lo = el;
  endtask

  task automatic done_fall(input string tag);
    @(negedge clk);
    total++;
    if (done !== 1'b0 || div_by_zero !== 1'b0) begin
      bad++; $display("FAIL %s pulse_width got=%b%b want=00", tag, done, div_by_zero);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 2'd0; A_opdat = 32'd0; B_opdat = 32'd0;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      bad++; $display("FAIL reset got=%b%b%b %h_%h want=000 0_0", busy, done, div_by_zero, hi, lo);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul();
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, "multu_max"); done_fall("multu_max");
    run_op(2'b01, 32'hFFFF_FFFD, 32'd7, -1, "mult_neg");           done_fall("mult_neg");
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, -1, "mult_min");   done_fall("mult_min");
  endtask

  task automatic test_div();
    run_op(2'b10, 32'd100, 32'd7, -1, "divu");                     done_fall("divu");
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, -1, "div_neg");            done_fall("div_neg");
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, -1, "div_wrap");   done_fall("div_wrap");
  endtask

  task automatic test_div_by_zero();
    run_op(2'b00, 32'h1234_5678, 32'h9ABC_DEF1, -1, "preload");    done_fall("preload");
    run_op(2'b11, 32'd5, 32'd0, -1, "div_zero");                   done_fall("div_zero");
    run_op(2'b10, 32'd9, 32'd0, -1, "divu_zero");                  done_fall("divu_zero");
  endtask

  task automatic test_ignore_start();
    run_op(2'b00, 32'h0001_0003, 32'h0000_0100, 5, "ignore_mul");  done_fall("ignore_mul");
    run_op(2'b10, 32'd1000, 32'd33, 3, "ignore_div");              done_fall("ignore_div");
  endtask

  task automatic test_back_to_back();
    run_op(2'b01, 32'hFFFF_0000, 32'h0000_FFFF, -1, "b2b_first");
    run_op(2'b00, 32'hDEAD_BEEF, 32'h0000_0010, -1, "b2b_second");
    done_fall("b2b_second");
  endtask

  task automatic test_reset_mid();
    logic seen;
    start = 1'b1; op = 2'b00; A_opdat = $urandom; B_opdat = $urandom;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      bad++; $display("FAIL reset_mid got=%b%b %h_%h want=00 0_0", busy, done, hi, lo);
    end
    exp_hi = 32'd0; exp_lo = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL reset_mid done_after_abort got=%b want=0", seen); end
    run_op(2'b01, 32'h0000_0005, 32'hFFFF_FFFE, -1, "after_reset"); done_fall("after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      run_op(2'($urandom_range(0, 3)), pick(), pick(), -1, "random");
      if ($urandom_range(0, 1) == 0) done_fall("random");
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_by_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit for the MIPS datapath, sitting directly downstream of the register file. It consumes the two operand read ports (rs → A, rt → B) and computes MULT/MULTU/DIV/DIVU into architectural HI/LO registers over 33 cycles. A start/busy/done handshake lets the control FSM stall the pipeline. HI/LO are presented continuously for MFHI/MFLO.

## Interface
Parameters:
- none (width fixed at 32; iteration count fixed at 32)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- A_opdat  input  32  operand A (register file A_readdat1; multiplicand / dividend)
- B_opdat  input  32  operand B (register file B_readdat2; multiplier / divisor)
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse, HI/LO valid and updated
- div_by_zero  output  1  one-cycle pulse coincident with done for DIV/DIVU with B=0
- hi  output  32  HI register (product[63:32] / remainder)
- lo  output  32  LO register (product[31:0] / quotient)

## Operation
- States: IDLE, CALC, FIX.
- IDLE: start=1 latches op, A_opdat, B_opdat; signed ops (01, 11) latch magnitudes and record sign of A and sign of B. → CALC, counter=0. Divide op with B=0 → FIX directly.
- CALC: one iteration per cycle, counter 0..31; at counter=31 → FIX.
  - Multiply: shift-add on 64-bit accumulator {hi_acc, lo_acc}; unsigned 32×32 → 64.
  - Divide: restoring division; 33-bit trial subtract of divisor from partial remainder, quotient bit shifted in.
- FIX: sign correction, commit to hi/lo, pulse done, → IDLE.
  - MULT: 64-bit product negated (two's complement) if signs differ.
  - DIV: quotient negated if signs differ; remainder takes sign of dividend.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000 (natural wrap, no flag).
  - Divide by zero: hi/lo unchanged, div_by_zero=1 with done.
- hi/lo change only at the FIX edge; they hold otherwise.
- start while busy=1 is ignored (not queued).

## Timing
- Reset values: busy=0, done=0, div_by_zero=0, hi=0, lo=0, state=IDLE, counter=0.
- Start accepted at edge N → busy=1 from edge N; CALC at edges N+1..N+32; FIX commit at edge N+33: hi/lo updated, done=1 for the cycle after edge N+33, busy=0 from edge N+33.
- Latency start→done: 33 cycles; divide by zero: 1 cycle (done after edge N+1).
- Back-to-back: start high in the done cycle is accepted (state is IDLE); the new operation's busy rises at that edge, done falls.
- Operands need only be valid in the start cycle; later changes on A_opdat/B_opdat have no effect.
- rst mid-operation: immediate abort, all outputs to reset values, no done pulse, HI/LO cleared.

## Configuration
- MDU_DIV_EN defined: divide datapath, DIV/DIVU and div_by_zero behave as above.
- MDU_DIV_EN undefined: divide hardware omitted; op 10/11 accepted, go IDLE→FIX, done pulses after 1 cycle with hi/lo unchanged and div_by_zero=0; multiply behaviour identical.

## Test plan
- Reset, then MULTU A=0xFFFFFFFF B=0xFFFFFFFF → done 33 cycles after start, hi=0xFFFFFFFE lo=0x00000001, busy low with done.
- MULT A=0xFFFFFFFD (−3) B=0x00000007 → hi=0xFFFFFFFF lo=0xFFFFFFEB; then MULT 0x80000000×0x80000000 → hi=0x40000000 lo=0x00000000.
- DIVU A=100 B=7 → lo=0x0000000E hi=0x00000002; DIV A=0xFFFFFFF9 (−7) B=2 → lo=0xFFFFFFFD hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF → lo=0x80000000 hi=0.
- DIV A=5 B=0 with hi/lo preloaded → done and div_by_zero one cycle after start, hi/lo unchanged.
- Start pulse during busy with different operands → ignored, result matches first operation; start in done cycle → second operation accepted, completes 33 cycles later.
- Assert rst at cycle 10 of a MULTU → busy/done/hi/lo all 0 immediately, no done pulse; next start operates normally.
